// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single outstanding word fetches to the
// instruction memory and buffers up to two {pc, instr} entries for decode.
// A redirect flushes the buffer, retargets fetch_pc and discards the data of
// any request that is still in flight.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request outstanding, waiting for buffer room
// WAIT  | request outstanding, response will be pushed into the FIFO
// DROP  | request outstanding, response will be thrown away
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;

    logic [31:0] pc_mem_q    [2];
    logic [31:0] instr_mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        issue;
    logic        push;
    logic        pop;
    logic [31:0] redirect_target;

    // Low two bits of the redirect target are forced to zero (word aligned).
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a response always ends the transaction, redirect
    // only decides whether its data is kept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / strobe decode. Issue is allowed with one entry buffered because
    // a single outstanding request can then fill at most the second slot.
    always_comb begin
        imem_req = (state_q != S_IDLE);
        issue    = (state_q == S_IDLE) && (count_q <= 2'd1) && !redirect;
        push     = (state_q == S_WAIT) && imem_ack && !redirect;
        pop      = out_valid && out_ready && !redirect;
    end

    // Fetch PC and latched request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Redirect wins over the +4 advance; the request address is captured only
    // at issue so it stays stable while fetch_pc moves underneath a DROP.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        if (redirect) begin
            fetch_pc_d = redirect_target;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (issue) begin
            req_addr_d = fetch_pc_q;
        end
    end

    assign imem_addr = req_addr_q;

    // FIFO pointer and occupancy update; flush on redirect.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO storage and pointers; the fetched word is tagged with fetch_pc,
    // which equals the address of the request being acknowledged in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
                instr_mem_q[wr_ptr_q] <= imem_rdata;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q != 2'd2));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= 2'd2);
    a_req_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [5];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, hold lat idle cycles, then acknowledge.
    task automatic serve(input int lat);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("serve_req_seen", {31'd0, imem_req}, 32'd1);
        repeat (lat) step();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        logic [31:0] dropped;
        logic [31:0] exp_pc;
        int          npops;
        logic        busy;
        int          lat;
        logic        prev_req, prev_ack, prev_redirect, prev_valid, prev_ready;
        logic [31:0] prev_addr, prev_pc, prev_instr;

        vecs[0] = '{32'h0000_0403, 32'h0000_0400, 32'h0000_0404};
        vecs[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
        vecs[3] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        step();
        step();

        chk("rst_req",   {31'd0, imem_req},  32'd0);
        chk("rst_addr",  imem_addr,          RESET_PC);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr,          32'd0);
        chk("rst_pc",    out_pc,             32'd0);

        // Reset release: request rises on the first edge.
        rst_n = 1'b1;
        step();
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr,         RESET_PC);

        // Streaming with decode always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            serve(1);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc",    out_pc,             32'(k * 4));
            chk("stream_instr", out_instr,          mem_word(32'(k * 4)));
        end

        // Back-pressure: buffer fills to two entries and fetching stops.
        out_ready = 1'b0;
        serve(1);
        chk("bp_head_pc", out_pc, 32'h8);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req || !out_valid || out_pc != 32'h8) bad++;
        end
        chk("bp_stall_cycles", 32'(bad), 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_second_pc",    out_pc,             32'hC);
        chk("bp_second_instr", out_instr,          mem_word(32'hC));
        chk("bp_no_req_full",  {31'd0, imem_req},  32'd0);
        step();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_req_resume", {31'd0, imem_req}, 32'd1);
        chk("bp_addr_resume", imem_addr, 32'h10);

        // Reset pulse during WAIT, with an ack that must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h10);
        rst_n      = 1'b0;
        #1;
        chk("midrst_req",   {31'd0, imem_req},  32'd0);
        chk("midrst_addr",  imem_addr,          RESET_PC);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_pc",    out_pc,             32'd0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        step();
        rst_n = 1'b1;
        step();
        chk("restart_req",   {31'd0, imem_req},  32'd1);
        chk("restart_addr",  imem_addr,          RESET_PC);
        chk("restart_valid", {31'd0, out_valid}, 32'd0);

        serve(0);
        chk("restart_pc0", out_pc, RESET_PC);
        serve(0);
        chk("restart_pc4", out_pc, RESET_PC + 32'd4);
        step();
        chk("wait8_addr", imem_addr, 32'h8);

        // Redirect while WAIT at 0x8, ack arrives three cycles later.
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            if (!imem_req || imem_addr != 32'h8 || out_valid) bad++;
            step();
        end
        if (!imem_req || imem_addr != 32'h8 || out_valid) bad++;
        chk("drop_hold", 32'(bad), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h8);
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("drop_discard_valid", {31'd0, out_valid}, 32'd0);
        chk("drop_req_low",       {31'd0, imem_req},  32'd0);
        step();
        chk("drop_next_req",   {31'd0, imem_req},  32'd1);
        chk("drop_next_addr",  imem_addr,          32'h100);
        chk("drop_next_valid", {31'd0, out_valid}, 32'd0);
        serve(1);
        chk("target_pc",    out_pc,    32'h100);
        chk("target_instr", out_instr, mem_word(32'h100));

        // Misaligned redirect target, issued from IDLE.
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        chk("align_flush", {31'd0, out_valid}, 32'd0);
        chk("align_noreq", {31'd0, imem_req},  32'd0);
        step();
        chk("align_req",  {31'd0, imem_req}, 32'd1);
        chk("align_addr", imem_addr,         32'h200);

        // Redirect coincident with ack and pop.
        out_ready = 1'b0;
        serve(0);
        step();
        chk("coinc_addr", imem_addr, 32'h204);
        chk("coinc_head", out_pc,    32'h200);
        dropped     = mem_word(32'h204);
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        imem_ack    = 1'b1;
        imem_rdata  = dropped;
        step();
        redirect   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk("coinc_empty", {31'd0, out_valid}, 32'd0);
        chk("coinc_noreq", {31'd0, imem_req},  32'd0);
        bad = 0;
        if (out_instr == dropped) bad++;
        step();
        chk("coinc_addr_new", imem_addr, 32'h300);
        serve(0);
        if (out_instr == dropped) bad++;
        chk("coinc_never_seen", 32'(bad), 32'd0);
        chk("coinc_new_pc", out_pc, 32'h300);

        // Table of redirect targets, each applied from IDLE.
        for (int v = 0; v < 5; v++) begin
            redirect    = 1'b1;
            redirect_pc = vecs[v].rpc;
            step();
            redirect = 1'b0;
            chk("tbl_flush", {31'd0, out_valid}, 32'd0);
            step();
            chk("tbl_addr", imem_addr, vecs[v].exp_addr);
            serve(0);
            chk("tbl_pc",    out_pc,    vecs[v].exp_addr);
            chk("tbl_instr", out_instr, mem_word(vecs[v].exp_addr));
            step();
            chk("tbl_next_addr", imem_addr, vecs[v].exp_next);
            serve(0);
            chk("tbl_next_pc", out_pc, vecs[v].exp_next);
        end

        // Randomized traffic against an in-order stream model.
        rst_n     = 1'b0;
        imem_ack  = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        npops  = 0;
        busy   = 1'b0;
        lat    = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_redirect = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_instr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_req && !prev_ack) begin
                chk("rnd_req_hold",  {31'd0, imem_req}, 32'd1);
                chk("rnd_addr_hold", imem_addr,         prev_addr);
            end
            if (prev_redirect) chk("rnd_flush", {31'd0, out_valid}, 32'd0);
            if (prev_valid && !prev_ready && !prev_redirect) begin
                chk("rnd_stall_pc",    out_pc,    prev_pc);
                chk("rnd_stall_instr", out_instr, prev_instr);
            end

            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            imem_ack    = 1'b0;
            imem_rdata  = '0;
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    lat  = $urandom_range(0, 3);
                end
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    busy       = 1'b0;
                end else begin
                    lat--;
                end
            end else begin
                busy = 1'b0;
            end

            if (out_valid && out_ready && !redirect) begin
                chk("rnd_pop_pc",    out_pc,    exp_pc);
                chk("rnd_pop_instr", out_instr, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                npops++;
            end
            if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;

            prev_req      = imem_req;
            prev_ack      = imem_ack;
            prev_redirect = redirect;
            prev_valid    = out_valid;
            prev_ready    = out_ready;
            prev_addr     = imem_addr;
            prev_pc       = out_pc;
            prev_instr    = out_instr;
            step();
        end
        chk("rnd_progress", {31'd0, npops >= 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory request, level, held until acknowledged.
REQ-005 The block SHALL have port imem_addr  output  32  word address of the outstanding request.
REQ-006 The block SHALL have port imem_ack  input  1  response strobe, imem_rdata valid in the same cycle.
REQ-007 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 The block SHALL have port out_valid  output  1  out_instr/out_pc hold a valid entry for decode.
REQ-009 The block SHALL have port out_instr  output  32  instruction at FIFO head, consumed by the control unit.
REQ-010 The block SHALL have port out_pc  output  32  address of out_instr.
REQ-011 The block SHALL have port out_ready  input  1  decode accepts the head entry this cycle.
REQ-012 The block SHALL have port redirect  input  1  taken branch/jump, one-cycle pulse.
REQ-013 The block SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.

Function
REQ-014 The block SHALL keep a fetch_pc register; each accepted response SHALL advance fetch_pc by 4, wrapping modulo 2^32.
REQ-015 The block SHALL allow at most one outstanding memory request.
REQ-016 The state machine SHALL have states IDLE (no request), WAIT (request outstanding, data kept), DROP (request outstanding, data discarded).
REQ-017 IDLE->WAIT SHALL occur when FIFO count <= 1 and no redirect; imem_req rises the same cycle with imem_addr = fetch_pc.
REQ-018 imem_req and imem_addr SHALL remain stable in WAIT and DROP until the imem_ack cycle inclusive.
REQ-019 In WAIT, on imem_ack without redirect, {fetch_pc, imem_rdata} SHALL be pushed and the state SHALL return to IDLE.
REQ-020 In DROP, on imem_ack, data SHALL be discarded, fetch_pc SHALL be unchanged and the state SHALL return to IDLE.
REQ-021 The FIFO SHALL hold 2 entries of {pc, instr}; the push/issue rule SHALL guarantee a push never targets a full FIFO.
REQ-022 out_valid SHALL be 1 exactly when count > 0; out_instr/out_pc SHALL show the head entry, registered and stable while out_valid && !out_ready.
REQ-023 A pop SHALL occur when out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 Latency: imem_ack in cycle N SHALL give out_valid = 1 in cycle N+1 when the FIFO was empty.
REQ-025 On redirect, the FIFO SHALL be flushed (count 0, out_valid 0 next cycle) and fetch_pc SHALL load {redirect_pc[31:2], 2'b00}.
REQ-026 Redirect in WAIT without imem_ack SHALL move to DROP; redirect with imem_ack SHALL discard that data and go to IDLE.
REQ-027 Redirect SHALL take priority over push, pop and issue in the same cycle.
REQ-028 Redirect in IDLE SHALL go to IDLE; the first fetch from the new address SHALL issue the following cycle.
REQ-029 Redirect in DROP SHALL only update fetch_pc; the state SHALL remain DROP.

Reset
REQ-030 While rst_n = 0 the outputs SHALL be imem_req = 0, imem_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0.
REQ-031 While rst_n = 0 the internal state SHALL be state = IDLE, fetch_pc = RESET_PC, FIFO count = 0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; an imem_ack while rst_n = 0 SHALL be ignored.
REQ-033 The first imem_req SHALL rise in the first clock edge after rst_n deasserts.

Verification
REQ-034 The bench SHALL cover: reset release, memory acks 1 cycle after each req, out_ready = 1 -> out_pc sequence 0x0, 0x4, 0x8, with out_instr matching memory.
REQ-035 The bench SHALL cover: out_ready = 0 for 10 cycles -> exactly 2 entries buffered, imem_req stays 0 after the second ack, no entry lost when out_ready returns to 1.
REQ-036 The bench SHALL cover: redirect to 0x100 while WAIT at 0x8 with ack 3 cycles later -> state DROP, ack data discarded, next imem_addr = 0x100, out_valid 0 until its ack.
REQ-037 The bench SHALL cover: redirect_pc = 0x203 -> imem_addr = 0x200.
REQ-038 The bench SHALL cover: redirect coincident with imem_ack and pop -> FIFO empty next cycle, acked word never appears on out_instr.
REQ-039 The bench SHALL cover: rst_n pulsed low during WAIT -> outputs reset immediately, restart at RESET_PC.
